ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending end of the keyboard link, complementing the existing PS/2 receiver. It takes one command byte from the game logic (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic), runs the PS/2 host request-to-send sequence on the open-drain kb_clock/kb_data lines and reports the device acknowledge. It shares the PS/2 pins with the receiver through the top-level open-drain buffers and runs in the 50 MHz system domain.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for the keyboard link.
// This block runs the host request-to-send sequence on the open-drain kb_clock/kb_data lines.
// It shifts one command byte out with odd parity and then reports the device acknowledge.
// Optional build macro: PS2_TX_TIMEOUT_EN adds a 20-bit watchdog from REQ entry through ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       kb_clock_in,
  input  logic       kb_data_in,
  output logic       kb_clock_oe,
  output logic       kb_data_oe
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    frame_q, frame_d;   // {parity, data}, shifted out LSB first
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic          err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic clk_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wd_q, wd_d;
`else
  // The timeout limit has no effect without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  assign clk_fall    = clk_prev_q & ~clk_sync_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign kb_clock_oe = clk_oe_q;
  assign kb_data_oe  = dat_oe_q;

  // Pad synchronisers and the extra register for clock falling-edge detection.
  always_ff @(posedge clk50) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= kb_clock_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= kb_data_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      bit_q    <= '0;
      inh_q    <= '0;
      err_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      inh_q    <= inh_d;
      err_q    <= err_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  // Next-state and output logic for the request-to-send sequence.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    inh_d    = inh_q;
    err_d    = err_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (tx_start) begin
          frame_d  = {~^tx_data, tx_data};
          bit_d    = '0;
          inh_d    = '0;
          err_d    = 1'b0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d     = '0;
`endif
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (clk_fall) begin
          dat_oe_d = ~frame_q[0];
          frame_d  = {1'b0, frame_q[8:1]};
          bit_d    = bit_q + 1'b1;
          if (bit_q == 4'd8) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (clk_fall) begin
          dat_oe_d = 1'b0;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          if (dat_sync_q) begin
            error_d = 1'b1;
            err_d   = 1'b1;
          end
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = ~err_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // The watchdog overrides whatever the case above decided, so an expiry always wins.
    if (state_q inside {S_REQ, S_SHIFT, S_STOP, S_ACK}) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_LIMIT) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b1;
        state_d  = S_IDLE;
      end
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       kb_clock_oe, kb_data_oe;
  logic       kb_clock_pad, kb_data_pad;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic dev_ack = 1'b1;
  logic dev_check = 1'b1;
  logic dev_enable = 1'b1;
  logic dev_active = 1'b0;
  int   dev_rises = 0;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  bit         exp_bits[$];
  logic [1:0] exp_out[$];
  logic [1:0] mon_e;
  bit         dev_exp;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       parity;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[4];

  assign kb_clock_pad = dev_clk & ~kb_clock_oe;
  assign kb_data_pad  = dev_data & ~kb_data_oe;

  always #10 clk50 = ~clk50;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .kb_clock_in (kb_clock_pad),
    .kb_data_in  (kb_data_pad),
    .kb_clock_oe (kb_clock_oe),
    .kb_data_oe  (kb_data_oe)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Device model: answers a request with 11 clocks, reads host bits on rising edges.
  task automatic run_device();
    dev_active = 1'b1;
    dev_rises  = 0;
    repeat (10) @(negedge clk50);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk50);
      dev_clk = 1'b1;
      if (k <= 10) begin
        dev_rises = k;
        if (dev_check) begin
          check("bit_queue_nonempty", int'(exp_bits.size() > 0), 1);
          if (exp_bits.size() > 0) begin
            dev_exp = exp_bits.pop_front();
            check($sformatf("frame_bit%0d", k), int'(kb_data_pad), int'(dev_exp));
          end
        end
      end
      if (k == 10 && dev_ack) dev_data = 1'b0;
      repeat (H) @(negedge clk50);
    end
    repeat (5) @(negedge clk50);
    dev_data   = 1'b1;
    dev_active = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk50);
      if (dev_enable && !kb_clock_oe && kb_data_oe) run_device();
    end
  end

  // Outcome scoreboard: every done/error pulse must match the next queued expectation.
  always @(negedge clk50) begin
    if (tx_done || tx_error) begin
      pulse_cnt++;
      check("pulse_expected", int'(exp_out.size() > 0), 1);
      if (exp_out.size() > 0) begin
        mon_e = exp_out.pop_front();
        check("tx_done", int'(tx_done), int'(mon_e[1]));
        check("tx_error", int'(tx_error), int'(mon_e[0]));
        if (mon_e[1]) check("busy_falls_with_done", int'(tx_busy), 0);
      end
    end
  end

  task automatic start_frame(input logic [7:0] d);
    int cnt;
    @(negedge clk50);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk50);
    #1;
    tx_start = 1'b0;
    check("busy_after_accept", int'(tx_busy), 1);
    check("clock_oe_after_accept", int'(kb_clock_oe), 1);
    cnt = 0;
    while (kb_clock_oe && cnt < 4 * INH) begin
      @(posedge clk50);
      #1;
      cnt++;
    end
    check("inhibit_cycles", cnt, INH);
    check("data_oe_at_req", int'(kb_data_oe), 1);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (tx_busy && n < 4000) begin
      @(negedge clk50);
      n++;
    end
    check("busy_clears", int'(tx_busy), 0);
  endtask

  task automatic wait_dev_idle();
    int n = 0;
    @(negedge clk50);
    while (dev_active && n < 4000) begin
      @(negedge clk50);
      n++;
    end
    check("device_idle", int'(dev_active), 0);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
  endtask

  initial begin
    int n;
    int p0;
    int busy_cnt;

    vecs[0] = '{data: 8'hED, ack: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'h01, ack: 1'b1, parity: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'h3C, ack: 1'b0, parity: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{data: 8'h80, ack: 1'b1, parity: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    repeat (5) @(posedge clk50);
    #1;
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_error", int'(tx_error), 0);
    check("rst_clock_oe", int'(kb_clock_oe), 0);
    check("rst_data_oe", int'(kb_data_oe), 0);
    @(negedge clk50);
    reset = 1'b0;
    repeat (5) @(negedge clk50);

    for (int i = 0; i < 4; i++) begin
      push_frame(vecs[i].data, vecs[i].parity);
      exp_out.push_back({vecs[i].exp_done, vecs[i].exp_err});
      dev_ack = vecs[i].ack;
      start_frame(vecs[i].data);
      wait_not_busy();
      check("released_clock", int'(kb_clock_oe), 0);
      check("released_data", int'(kb_data_oe), 0);
      wait_dev_idle();
    end
    dev_ack = 1'b1;

    // tx_start while busy must be ignored and the frame keeps its original byte.
    push_frame(8'hA6, 1'b1);
    exp_out.push_back(2'b10);
    start_frame(8'hA6);
    n = 0;
    while (dev_rises < 2 && n < 2000) begin
      @(negedge clk50);
      n++;
    end
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk50);
    tx_start = 1'b0;
    check("busy_mid_frame", int'(tx_busy), 1);
    wait_not_busy();
    wait_dev_idle();
    repeat (50) @(negedge clk50);
    check("no_queued_busy", int'(tx_busy), 0);
    check("no_queued_clock_oe", int'(kb_clock_oe), 0);

    // Reset during SHIFT bit 4 aborts the frame without any pulse.
    dev_check = 1'b0;
    start_frame(8'h9B);
    n = 0;
    while (dev_rises != 4 && n < 2000) begin
      @(negedge clk50);
      n++;
    end
    check("reached_bit4", dev_rises, 4);
    p0 = pulse_cnt;
    reset = 1'b1;
    @(posedge clk50);
    #1;
    check("abort_clock_oe", int'(kb_clock_oe), 0);
    check("abort_data_oe", int'(kb_data_oe), 0);
    check("abort_busy", int'(tx_busy), 0);
    @(negedge clk50);
    reset = 1'b0;
    wait_dev_idle();
    check("abort_no_pulse", pulse_cnt, p0);
    dev_check = 1'b1;

    push_frame(8'hFF, 1'b1);
    exp_out.push_back(2'b10);
    start_frame(8'hFF);
    wait_not_busy();
    wait_dev_idle();

    // Absent device: the block waits in REQ/SHIFT.
    dev_enable = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    exp_out.push_back(2'b01);
    start_frame(8'h12);
    n = 0;
    while (!tx_error && n < TO + 1000) begin
      @(posedge clk50);
      #1;
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_data_oe", int'(kb_data_oe), 0);
    check("timeout_clock_oe", int'(kb_clock_oe), 0);
    check("timeout_busy", int'(tx_busy), 0);
`else
    start_frame(8'h12);
    busy_cnt = 0;
    for (int j = 0; j < TO + 100; j++) begin
      @(negedge clk50);
      if (tx_busy) busy_cnt++;
    end
    check("no_watchdog_busy", busy_cnt, TO + 100);
    reset = 1'b1;
    @(posedge clk50);
    #1;
    check("stuck_reset_busy", int'(tx_busy), 0);
    check("stuck_reset_data_oe", int'(kb_data_oe), 0);
    @(negedge clk50);
    reset = 1'b0;
`endif
    repeat (20) @(negedge clk50);
    check("outcomes_all_seen", exp_out.size(), 0);
    check("bits_all_seen", exp_bits.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1800000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
